instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Top-level instruction sequencer for the simple CPU. It fetches 16-bit instruction words from instruction memory and decodes the opcode. It then pulses the `start` of the matching execution FSM (Mov, Movi, Add, …) and waits for that unit's `done` before fetching again. It owns the program counter and presents the decoded register/immediate fields to all execution units.

## Interface
Parameters:
- PC_W, 8, program counter / instruction address width
- UNIT_MASK, 16'h008E, bit k set = opcode k has an execution unit (default: 1 Mov, 2 Add, 3 Sub, 7 Movi)
- TIMEOUT, 15, max cycles spent in WAIT before fault (1..255)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- run  in  1  level; begin/continue execution from IDLE
- stop  in  1  level; finish current instruction, then go to IDLE
- mem_addr  out  PC_W  instruction address (= pc)
- mem_rd  out  1  instruction read request
- mem_ack  in  1  instruction word valid on mem_data this cycle
- mem_data  in  16  instruction word: [15:12] opcode, [11:6] Ri, [5:0] Rj/num
- start  out  16  one-hot start pulse, bit = opcode
- done  in  16  per-unit done, bit = opcode
- ri_out  out  6  IR[11:6]
- arg_out  out  6  IR[5:0]
- busy  out  1  state not IDLE/HALTED/FAULT
- halted  out  1  HALT executed
- fault  out  1  fault latched
- fault_code  out  2  0 none, 1 illegal opcode, 2 unit timeout

## Operation
States: IDLE, FETCH, DECODE, EXEC, WAIT, HALTED, FAULT.
- Reset (reset=0 at edge):
  - state=IDLE, pc=0, ir=0, tcnt=0.
  - All outputs 0; fault_code=0.
- IDLE: if run=1 → FETCH; else stay.
- FETCH:
  - mem_rd=1 and mem_addr=pc while in FETCH.
  - When mem_ack=1: ir<=mem_data, pc<=pc+1 (mod 2^PC_W; wraps 2^PC_W−1→0 silently), → DECODE.
  - Without mem_ack: stay; stop is ignored here.
- DECODE (op = ir[15:12]):
  - op=0 (NOP): if stop → IDLE, else → FETCH.
  - op=15 (HALT): → HALTED.
  - UNIT_MASK[op]=1: → EXEC.
  - Otherwise: fault_code<=1 → FAULT.
- EXEC: start[op]=1 for exactly this cycle; tcnt<=0; → WAIT.
- WAIT:
  - Only done[op] is observed; other done bits are ignored.
  - done[op]=1: if stop → IDLE, else → FETCH.
  - Otherwise tcnt++. When tcnt reaches TIMEOUT with done[op] still 0: fault_code<=2 → FAULT.
  - done[op] and timeout in the same cycle: done wins.
- HALTED: halted=1; stays until reset. run and stop are ignored.
- FAULT: fault=1 with fault_code held; stays until reset.
- ri_out/arg_out:
  - Driven continuously from ir and stable from DECODE through WAIT.
  - Units that latch Ri/num at start see valid fields.
- Sequencer never drives the data bus. Bus ownership follows from only one start being issued at a time.
- stop is a level, sampled only in DECODE (NOP) and at WAIT completion. Deasserting it before then cancels it.

## Timing
- Reset is synchronous: takes effect at the first rising edge with reset=0, including mid-FETCH or mid-WAIT. start and mem_rd drop that same edge. The interrupted unit FSM is reset by the shared system reset.
- start, mem_rd and busy are registered-state decodes (Moore), so they are glitch-free per state.
- Minimum instruction period, with mem_ack in the first FETCH cycle and a 2-cycle unit (Movi: start at T, done at T+2):
  - FETCH (1) + DECODE (1) + EXEC (1) + WAIT (2) = 5 cycles.
  - NOP takes 2 cycles.
- start is asserted exactly one cycle per dispatched instruction. It is never asserted in back-to-back cycles.
- A done that is high at EXEC is not sampled. It is first examined in the first WAIT cycle.
- Timeout: with done[op] never asserted, FAULT is entered exactly TIMEOUT+1 cycles after the EXEC cycle.
- pc increments exactly once per accepted mem_ack.

## Test plan
- Reset/idle: hold reset=0 for 2 cycles with run=0 → all outputs 0, pc=0, mem_rd stays 0 for 10 cycles.
- Movi dispatch: run=1, mem_data=16'h7043 acked immediately, Movi model returns done 2 cycles after start → start=16'h0080 for one cycle, ri_out=1, arg_out=3, next mem_rd with mem_addr=1 five cycles after the first mem_rd.
- NOP/HALT and wrap: PC_W=2, program NOP,NOP,NOP,NOP then word at addr 0 = 16'hF000 on the second pass → mem_addr sequence 0,1,2,3,0; halted=1, busy=0; run toggling has no effect.
- Illegal opcode: mem_data=16'h4000 (UNIT_MASK bit4=0) → no start pulse, fault=1, fault_code=1, mem_rd stays 0.
- Timeout vs done boundary:
  - Add (16'h2000) with done withheld → fault_code=2 exactly TIMEOUT+1 cycles after start.
  - Repeat with done[2] asserted on the TIMEOUT-th WAIT cycle → no fault, next FETCH.
- Stop and mid-op reset:
  - stop=1 during WAIT of a Mov → returns to IDLE after done, busy=0, pc=1.
  - Separate run: reset=0 while mem_rd is waiting for ack → IDLE and mem_rd=0 on the next edge.

Source files
------------

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer_if
// Brief    : Instruction-memory bus and execution-unit start/done/field bundle
// Revision : 1.0
// ============================================================================

interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] mem_addr;
    logic            mem_rd;
    logic            mem_ack;
    logic [15:0]     mem_data;
    logic [15:0]     start;
    logic [15:0]     done;
    logic [5:0]      ri_out;
    logic [5:0]      arg_out;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_ack,
        input  mem_data,
        output start,
        input  done,
        output ri_out,
        output arg_out
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_ack,
        output mem_data,
        input  start,
        output done,
        input  ri_out,
        input  arg_out
    );
endinterface

`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Fetch/decode/dispatch sequencer; owns the PC, pulses one unit start
//            per instruction and waits for that unit's done (with timeout).
// Revision : 1.0
// ============================================================================

module instr_sequencer #(
    parameter int          PC_W      = 8,
    parameter logic [15:0] UNIT_MASK = 16'h008E,
    parameter int          TIMEOUT   = 15
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              run,
    input  wire              stop,
    instr_sequencer_if.master bus,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_wait   = 3'd4;
    localparam logic [2:0] c_st_halted = 3'd5;
    localparam logic [2:0] c_st_fault  = 3'd6;

    localparam logic [3:0] c_op_nop  = 4'h0;
    localparam logic [3:0] c_op_halt = 4'hF;

    localparam logic [1:0] c_fc_none    = 2'd0;
    localparam logic [1:0] c_fc_illegal = 2'd1;
    localparam logic [1:0] c_fc_timeout = 2'd2;

    // Last WAIT cycle index before a missing done becomes a fault.
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [7:0]      r_tcnt;
    logic [1:0]      r_fault_code;

    logic [3:0]      w_op;
    logic [15:0]     w_op_onehot;
    logic            w_unit_done;
    logic            w_has_unit;
    logic            w_tmo_hit;

    assign w_op        = r_ir[15:12];
    assign w_op_onehot = 16'h0001 << w_op;
    assign w_unit_done = bus.done[w_op];
    assign w_has_unit  = UNIT_MASK[w_op];
    assign w_tmo_hit   = (r_tcnt == c_tmo_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (run) begin
                    w_state_nxt = c_st_fetch;
                end
            end
            c_st_fetch: begin
                if (bus.mem_ack) begin
                    w_state_nxt = c_st_decode;
                end
            end
            c_st_decode: begin
                if (w_op == c_op_nop) begin
                    w_state_nxt = stop ? c_st_idle : c_st_fetch;
                end else if (w_op == c_op_halt) begin
                    w_state_nxt = c_st_halted;
                end else if (w_has_unit) begin
                    w_state_nxt = c_st_exec;
                end else begin
                    w_state_nxt = c_st_fault;
                end
            end
            c_st_exec: begin
                w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
                // A done arriving on the final allowed cycle beats the timeout.
                if (w_unit_done) begin
                    w_state_nxt = stop ? c_st_idle : c_st_fetch;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_st_fault;
                end
            end
            c_st_halted: begin
                w_state_nxt = c_st_halted;
            end
            c_st_fault: begin
                w_state_nxt = c_st_fault;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_st_idle;
            r_pc         <= '0;
            r_ir         <= '0;
            r_tcnt       <= '0;
            r_fault_code <= c_fc_none;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == c_st_fetch) && bus.mem_ack) begin
                r_ir <= bus.mem_data;
                r_pc <= r_pc + 1'b1;
            end

            if (r_state == c_st_exec) begin
                r_tcnt <= '0;
            end else if ((r_state == c_st_wait) && !w_unit_done) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if ((r_state == c_st_decode) && (w_state_nxt == c_st_fault)) begin
                r_fault_code <= c_fc_illegal;
            end else if ((r_state == c_st_wait) && (w_state_nxt == c_st_fault)) begin
                r_fault_code <= c_fc_timeout;
            end
        end
    end

    // Control outputs decode the registered state only, so they cannot glitch.
    assign bus.mem_addr = r_pc;
    assign bus.mem_rd   = (r_state == c_st_fetch);
    assign bus.start    = (r_state == c_st_exec) ? w_op_onehot : 16'h0000;
    assign bus.ri_out   = r_ir[11:6];
    assign bus.arg_out  = r_ir[5:0];

    assign busy       = (r_state == c_st_fetch) || (r_state == c_st_decode) ||
                        (r_state == c_st_exec)  || (r_state == c_st_wait);
    assign halted     = (r_state == c_st_halted);
    assign fault      = (r_state == c_st_fault);
    assign fault_code = r_fault_code;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Brief    : Scoreboard bench for instr_sequencer with memory and unit models
// Revision : 1.0
// ============================================================================

module tb_instr_sequencer;

    localparam int c_pc_w    = 8;
    localparam int c_timeout = 15;

    typedef struct packed {
        logic [15:0] start;
        logic [5:0]  ri;
        logic [5:0]  arg;
    } start_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       stop = 1'b0;
    logic       busy;
    logic       halted;
    logic       fault;
    logic [1:0] fault_code;

    instr_sequencer_if #(.PC_W(c_pc_w)) bus ();

    instr_sequencer #(
        .PC_W      (c_pc_w),
        .UNIT_MASK (16'h008E),
        .TIMEOUT   (c_timeout)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .stop       (stop),
        .bus        (bus),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    logic [7:0]  exp_fetch [$];
    start_t      exp_start [$];
    int          rd_rise [$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_rd_cyc = 0;
    int          ack_delay = 0;
    int          ack_wait = 0;
    int          unit_lat = 0;
    bit          noise = 1'b0;
    bit          due_valid = 1'b0;
    int          due = 0;
    logic [15:0] due_bits = 16'h0;
    bit          prev_rd = 1'b0;
    bit          prev_start = 1'b0;
    bit          prev_fault = 1'b0;
    int          start_cyc = -1;
    int          fault_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder, execution-unit model and output monitors, all
    // evaluated 1 time unit after each rising edge.
    initial begin
        start_t e;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 16'h0;
        bus.done     = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.mem_rd) n_rd_cyc++;
            if (bus.mem_rd && !prev_rd) rd_rise.push_back(cyc);
            prev_rd = bus.mem_rd;

            if (bus.mem_rd && (ack_wait >= ack_delay)) begin
                if (exp_fetch.size() == 0) begin
                    chk("fetch_unexpected", exp_fetch.size(), 1);
                end else begin
                    chk("fetch_addr", bus.mem_addr, exp_fetch.pop_front());
                end
                bus.mem_ack  = 1'b1;
                bus.mem_data = mem[bus.mem_addr];
            end else begin
                bus.mem_ack  = 1'b0;
                ack_wait     = bus.mem_rd ? ack_wait + 1 : 0;
            end

            bus.done = 16'h0;
            if (bus.start != 16'h0) begin
                chk("start_gap", prev_start, 0);
                if (exp_start.size() == 0) begin
                    chk("start_unexpected", exp_start.size(), 1);
                end else begin
                    e = exp_start.pop_front();
                    chk("start", bus.start, e.start);
                    chk("ri_out", bus.ri_out, e.ri);
                    chk("arg_out", bus.arg_out, e.arg);
                end
                start_cyc = cyc;
                due_bits  = bus.start;
                due_valid = 1'b1;
                due       = (unit_lat > 0) ? cyc + unit_lat : 32'h7fffffff;
                // done bits raised during EXEC must not be sampled
                if (noise) bus.done = 16'hFFFF;
            end else if (due_valid) begin
                if (cyc == due) begin
                    bus.done  = noise ? 16'hFFFF : due_bits;
                    due_valid = 1'b0;
                end else if (noise) begin
                    bus.done = ~due_bits;
                end
            end
            prev_start = (bus.start != 16'h0);

            if (fault && !prev_fault) fault_cyc = cyc;
            prev_fault = fault;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_fetch.delete();
        exp_start.delete();
        rd_rise.delete();
        foreach (mem[i]) mem[i] = 16'h0;
        due_valid = 1'b0;
        noise     = 1'b0;
        start_cyc = -1;
        fault_cyc = -1;
        ack_delay = 0;
        unit_lat  = 0;
    endtask

    initial begin
        int n0;

        // Reset and idle
        do_reset();
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_start", bus.start, 0);
        chk("rst_fields", {bus.ri_out, bus.arg_out}, 0);
        chk("rst_status", {busy, halted, fault, fault_code}, 0);
        n0 = n_rd_cyc;
        repeat (10) @(negedge clk);
        chk("idle_no_rd", n_rd_cyc - n0, 0);

        // Movi dispatch followed by HALT
        do_reset();
        mem[0] = 16'h7043;
        mem[1] = 16'hF000;
        exp_fetch.push_back(8'd0);
        exp_fetch.push_back(8'd1);
        exp_start.push_back('{start: 16'h0080, ri: 6'd1, arg: 6'd3});
        unit_lat = 2;
        run = 1'b1;
        for (int i = 0; i < 50 && !halted; i++) @(negedge clk);
        run = 1'b0;
        chk("movi_halted", halted, 1);
        chk("movi_busy", busy, 0);
        chk("movi_rd_count", rd_rise.size(), 2);
        if (rd_rise.size() >= 2) begin
            chk("movi_period", rd_rise[1] - rd_rise[0], 5);
            chk("movi_start_lat", start_cyc - rd_rise[0], 2);
        end
        chk("movi_fetch_left", exp_fetch.size(), 0);
        chk("movi_start_left", exp_start.size(), 0);

        // NOP sweep across the whole PC range, wrap, HALT on second pass
        do_reset();
        for (int i = 0; i < 256; i++) exp_fetch.push_back(8'(i));
        exp_fetch.push_back(8'd0);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 10 && exp_fetch.size() > 256; i++) @(negedge clk);
        mem[0] = 16'hF000;
        for (int i = 0; i < 1000 && !halted; i++) @(negedge clk);
        chk("wrap_halted", halted, 1);
        chk("wrap_busy", busy, 0);
        chk("wrap_pc", bus.mem_addr, 1);
        chk("wrap_fetch_left", exp_fetch.size(), 0);
        if (rd_rise.size() >= 2) chk("nop_period", rd_rise[1] - rd_rise[0], 2);
        n0 = n_rd_cyc;
        for (int i = 0; i < 6; i++) begin
            run  = ~run;
            stop = (i % 3) == 0;
            @(negedge clk);
        end
        run  = 1'b0;
        stop = 1'b0;
        chk("halt_sticky", {halted, busy}, 2'b10);
        chk("halt_no_rd", n_rd_cyc - n0, 0);

        // Illegal opcode
        do_reset();
        mem[0] = 16'h4000;
        exp_fetch.push_back(8'd0);
        run = 1'b1;
        for (int i = 0; i < 20 && !fault; i++) @(negedge clk);
        chk("ill_fault", fault, 1);
        chk("ill_code", fault_code, 1);
        chk("ill_busy", busy, 0);
        n0 = n_rd_cyc;
        repeat (5) @(negedge clk);
        chk("ill_no_rd", n_rd_cyc - n0, 0);
        chk("ill_fetch_left", exp_fetch.size(), 0);

        // Unit timeout with done withheld (foreign done bits toggling)
        do_reset();
        mem[0] = 16'h2000;
        exp_fetch.push_back(8'd0);
        exp_start.push_back('{start: 16'h0004, ri: 6'd0, arg: 6'd0});
        unit_lat = 0;
        noise    = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 60 && !fault; i++) @(negedge clk);
        chk("tmo_fault", fault, 1);
        chk("tmo_code", fault_code, 2);
        chk("tmo_latency", fault_cyc - start_cyc, c_timeout + 1);

        // done on the last allowed WAIT cycle wins over the timeout
        do_reset();
        mem[0] = 16'h2000;
        mem[1] = 16'hF000;
        exp_fetch.push_back(8'd0);
        exp_fetch.push_back(8'd1);
        exp_start.push_back('{start: 16'h0004, ri: 6'd0, arg: 6'd0});
        unit_lat = c_timeout;
        noise    = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 60 && !halted && !fault; i++) @(negedge clk);
        chk("bnd_no_fault", {fault, fault_code}, 0);
        chk("bnd_halted", halted, 1);
        chk("bnd_rd_count", rd_rise.size(), 2);
        if (rd_rise.size() >= 2) chk("bnd_refetch", rd_rise[1] - start_cyc, c_timeout + 1);

        // stop raised while a Mov is executing
        do_reset();
        ack_delay = 2;
        mem[0] = 16'h1285;
        mem[1] = 16'hF000;
        exp_fetch.push_back(8'd0);
        exp_start.push_back('{start: 16'h0002, ri: 6'h0A, arg: 6'h05});
        unit_lat = 4;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 20 && start_cyc < 0; i++) @(negedge clk);
        stop = 1'b1;
        chk("stop_ri_hold", bus.ri_out, 6'h0A);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("stop_busy", busy, 0);
        chk("stop_flags", {halted, fault}, 0);
        chk("stop_pc", bus.mem_addr, 1);
        n0 = n_rd_cyc;
        repeat (5) @(negedge clk);
        chk("stop_no_rd", n_rd_cyc - n0, 0);
        stop = 1'b0;
        chk("stop_fetch_left", exp_fetch.size(), 0);

        // Reset while a fetch is waiting for its ack
        do_reset();
        ack_delay = 1000;
        run = 1'b1;
        for (int i = 0; i < 10 && !bus.mem_rd; i++) @(negedge clk);
        chk("mf_rd_seen", bus.mem_rd, 1);
        reset = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        chk("mf_rd_drop", bus.mem_rd, 0);
        chk("mf_busy", busy, 0);
        reset = 1'b1;
        n0 = n_rd_cyc;
        repeat (3) @(negedge clk);
        chk("mf_idle_no_rd", n_rd_cyc - n0, 0);
        ack_delay = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
